// File: rtl/aes_pkg.sv
// Shared AES types and constants used by the key schedule.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    localparam int NUM_ROUNDS = 10;

    // Round constants for rounds 1..10 (top byte of the XOR word).
    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } kexp_state_e;

    // Out-of-range rounds yield zero so the XOR network stays defined
    // while the last round key is being held.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        if (r >= 4'd1 && r <= 4'd10) return RCON[r];
        return 8'h00;
    endfunction

endpackage

// File: rtl/key_expansion_if.sv
// Handshake bundle between the key schedule and its consumer.
interface key_expansion_if;
    import aes_pkg::*;

    logic       start;
    block_t     key_in;
    logic       rk_ready;
    logic       rk_valid;
    block_t     round_key;
    logic [3:0] round_idx;
    logic       busy;
    logic       done;

    modport master (
        output start, key_in, rk_ready,
        input  rk_valid, round_key, round_idx, busy, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output rk_valid, round_key, round_idx, busy, done
    );
endinterface

// File: rtl/key_expansion_sbox.sv
// Combinational 32-bit SubWord: four parallel AES S-box lookups.
module key_expansion_sbox
    import aes_pkg::*;
(
    input  word_t din,
    output word_t dout
);

    // Byte 0 of the table sits at the MSB end, so SBOX[x] is S(x).
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // One lookup per byte lane; no register stage.
    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign dout[8*i +: 8] = SBOX[din[8*i +: 8]];
    end

endmodule

// File: rtl/key_expansion.sv
// AES-128 key schedule: emits round keys 0..10, one per valid/ready handshake.
module key_expansion
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    key_expansion_if.slave    bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0] state_q, state_d;
    block_t     key_q,   key_d;
    logic [3:0] idx_q,   idx_d;
    logic       done_q,  done_d;

    word_t w0, w1, w2, w3;
    word_t rot_w, sub_w, temp;
    word_t n0, n1, n2, n3;
    block_t next_key;

    assign {w0, w1, w2, w3} = key_q;
    assign rot_w = {w3[23:0], w3[31:24]};

    key_expansion_sbox u_sbox (
        .din  (rot_w),
        .dout (sub_w)
    );

    // Next round key from the current one; r = round_idx + 1.
    always_comb begin
        temp     = sub_w ^ {rcon_of(idx_q + 4'd1), 24'h0};
        n0       = w0 ^ temp;
        n1       = n0 ^ w1;
        n2       = n1 ^ w2;
        n3       = n2 ^ w3;
        next_key = {n0, n1, n2, n3};
    end

    // FSM, key register and round counter next-state logic.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    key_d   = bus.key_in;
                    idx_d   = 4'd0;
                    state_d = ST_EMIT;
                end
            end
            default: begin
                // start is ignored here, including on the final handshake
                if (bus.rk_ready) begin
                    if (idx_q == 4'(NUM_ROUNDS)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d = next_key;
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
        endcase
    end

    // State registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // All outputs come straight from flops; none depend on rk_ready.
    assign bus.rk_valid  = (state_q == ST_EMIT);
    assign bus.busy      = (state_q == ST_EMIT);
    assign bus.round_key = key_q;
    assign bus.round_idx = idx_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion against a textbook AES key schedule model.
module tb_key_expansion;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

    localparam int M_READY = 0;  // rk_ready held high
    localparam int M_RAND  = 1;  // random backpressure
    localparam int M_STALL = 2;  // 3-cycle stall at round 4
    localparam int M_START = 3;  // stray start at round 6
    localparam int M_RST   = 4;  // reset at round 7

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [7:0]   sbox_ref [256];
    logic [127:0] exp_keys [11];

    key_expansion_if bus ();

    key_expansion dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                              ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Word-array key expansion: w[i] = w[i-4] ^ f(w[i-1]).
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]],
                     sbox_ref[t[15:8]],  sbox_ref[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 11; j++)
            exp_keys[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [127:0] key, input logic [3:0] idx,
                            input logic done_exp);
        chk({tag, "_valid"}, 128'(bus.rk_valid), 128'd0);
        chk({tag, "_busy"},  128'(bus.busy),     128'd0);
        chk({tag, "_done"},  128'(bus.done),     128'(done_exp));
        chk({tag, "_idx"},   128'(bus.round_idx), 128'(idx));
        chk({tag, "_key"},   bus.round_key,      key);
    endtask

    task automatic drive_start(input logic [127:0] key);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.key_in = key;
    endtask

    // Walk one schedule after start was accepted; chain=1 starts nxt in the done cycle.
    task automatic run(input logic [127:0] key, input int mode, input bit chain,
                       input logic [127:0] nxt, input bit ref1, input logic [127:0] r1,
                       input bit ref10, input logic [127:0] r10);
        int r     = 0;
        int stall = 0;
        bit fin   = 1'b0;
        expand(key);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            chk("valid", 128'(bus.rk_valid),  128'd1);
            chk("busy",  128'(bus.busy),      128'd1);
            chk("done",  128'(bus.done),      128'd0);
            chk("idx",   128'(bus.round_idx), 128'(r));
            chk("key",   bus.round_key,       exp_keys[r]);
            if (ref1 && r == 1)   chk("ref_r1",  bus.round_key, r1);
            if (ref10 && r == 10) chk("ref_r10", bus.round_key, r10);
            if (mode == M_RST && r == 7) begin
                rst_n = 1'b0;
                #1;
                chk_idle("rst", 128'd0, 4'd0, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (mode == M_START && r == 6) begin
                bus.start  = 1'b1;
                bus.key_in = ~key;
            end
            if (mode == M_STALL && r == 4 && stall < 3) begin
                bus.rk_ready = 1'b0;
                stall++;
            end else if (mode == M_RAND) begin
                bus.rk_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.rk_ready = 1'b1;
            end
            if (bus.rk_ready) begin
                if (r == 10) fin = 1'b1;
                else r++;
            end
        end
        if (!fin) begin
            chk("timeout", 128'd0, 128'd1);
            return;
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk_idle("fin", exp_keys[10], 4'd10, 1'b1);
        if (chain) begin
            bus.start  = 1'b1;
            bus.key_in = nxt;
        end else begin
            @(negedge clk);
            chk_idle("post", exp_keys[10], 4'd10, 1'b0);
        end
    endtask

    initial begin
        logic [127:0] k1, k2;
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.key_in   = '0;
        bus.rk_ready = 1'b0;
        build_sbox();

        repeat (2) @(negedge clk);
        chk_idle("reset", 128'd0, 4'd0, 1'b0);
        rst_n = 1'b1;

        // FIPS-197 vector, no backpressure: rounds on 11 consecutive cycles, done next.
        drive_start(FIPS_KEY);
        run(FIPS_KEY, M_READY, 1'b0, '0, 1'b1, FIPS_R1, 1'b1, FIPS_R10);

        // All-zero key.
        drive_start(128'd0);
        run(128'd0, M_READY, 1'b0, '0, 1'b1, ZERO_R1, 1'b0, '0);

        // Backpressure at round 4.
        drive_start(FIPS_KEY);
        run(FIPS_KEY, M_STALL, 1'b0, '0, 1'b1, FIPS_R1, 1'b1, FIPS_R10);

        // Stray start at round 6.
        drive_start(FIPS_KEY);
        run(FIPS_KEY, M_START, 1'b0, '0, 1'b1, FIPS_R1, 1'b1, FIPS_R10);

        // Reset at round 7, then a clean restart.
        drive_start(FIPS_KEY);
        run(FIPS_KEY, M_RST, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        drive_start(FIPS_KEY);
        run(FIPS_KEY, M_READY, 1'b0, '0, 1'b1, FIPS_R1, 1'b1, FIPS_R10);

        // Random keys with random backpressure.
        for (int n = 0; n < 4; n++) begin
            k1 = {$urandom, $urandom, $urandom, $urandom};
            drive_start(k1);
            run(k1, M_RAND, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        end

        // Back-to-back: second start issued in the done cycle.
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        drive_start(k1);
        run(k1, M_READY, 1'b1, k2, 1'b0, '0, 1'b0, '0);
        run(k2, M_RAND, 1'b0, '0, 1'b0, '0, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
